vx_writeback_arb: RTL

//  Producer side of the per-issue-slot writeback interface consumed by the operand/GPR stage.

---
 rtl/vx_writeback_arb_pkg.sv | 31 +++
 rtl/vx_rr_lock_arbiter.sv | 50 +++++
 rtl/vx_writeback_arb.sv | 115 +++++++++++
 3 files changed

// File: rtl/vx_writeback_arb_pkg.sv
// Shared types for the writeback arbiter: lock FSM states, the writeback beat layout
// at the default geometry, and an index-width helper that stays >= 1 for single-source builds.
package vx_writeback_arb_pkg;

  localparam int DEF_NUM_THREADS = 4;
  localparam int DEF_XLEN        = 32;
  localparam int DEF_NR_BITS     = 6;
  localparam int DEF_WIS_W       = 2;
  localparam int DEF_UUID_W      = 44;

  typedef enum logic {
    WB_ARB_IDLE   = 1'b0,
    WB_ARB_LOCKED = 1'b1
  } wb_arb_state_e;

  typedef struct packed {
    logic [DEF_UUID_W-1:0]               uuid;
    logic [DEF_WIS_W-1:0]                wis;
    logic [DEF_NUM_THREADS-1:0]          tmask;
    logic [DEF_XLEN-1:0]                 PC;
    logic [DEF_NR_BITS-1:0]              rd;
    logic [DEF_NUM_THREADS*DEF_XLEN-1:0] data;
    logic                                sop;
    logic                                eop;
  } wb_beat_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// N-way round-robin arbiter; while lock is high only lock_idx can win, so an open
// packet keeps its source until the top releases the lock.
module vx_rr_lock_arbiter
  import vx_writeback_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     valid,
  input  logic             lock,
  input  logic [IDX_W-1:0] lock_idx,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int   j;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    if (lock) begin
      grant_idx       = lock_idx;
      grant[lock_idx] = valid[lock_idx];
    end else begin
      for (int k = 0; k < N; k++) begin
        j = (int'(ptr) + k) % N;
        if (!found && valid[j]) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

  // Pointer moves past every winner, including beats granted under lock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ptr <= '0;
    else if (|grant)
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/vx_writeback_arb.sv
// Merges commit streams into one registered writeback beat per cycle; sop..eop packets
// from one source are kept contiguous by locking the arbiter until eop is accepted.
module vx_writeback_arb
  import vx_writeback_arb_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int NR_BITS     = 6,
  parameter int WIS_W       = 2,
  parameter int UUID_W      = 44
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_INPUTS-1:0]              in_valid,
  output logic [NUM_INPUTS-1:0]              in_ready,
  input  logic [NUM_INPUTS*UUID_W-1:0]       in_uuid,
  input  logic [NUM_INPUTS*WIS_W-1:0]        in_wis,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0]  in_tmask,
  input  logic [NUM_INPUTS*XLEN-1:0]         in_PC,
  input  logic [NUM_INPUTS*NR_BITS-1:0]      in_rd,
  input  logic [NUM_INPUTS*NUM_THREADS*XLEN-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]              in_sop,
  input  logic [NUM_INPUTS-1:0]              in_eop,
  output logic                               wb_valid,
  output logic [UUID_W-1:0]                  wb_uuid,
  output logic [WIS_W-1:0]                   wb_wis,
  output logic [NUM_THREADS-1:0]             wb_tmask,
  output logic [XLEN-1:0]                    wb_PC,
  output logic [NR_BITS-1:0]                 wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]        wb_data,
  output logic                               wb_sop,
  output logic                               wb_eop
);

  localparam int IDX_W = idx_width(NUM_INPUTS);
  localparam int DW    = NUM_THREADS * XLEN;

  wb_arb_state_e         state, state_n;
  logic [IDX_W-1:0]      lock_src, lock_src_n;
  logic [NUM_INPUTS-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  fire, sel_sop, sel_eop, proto_err;

  // Masking valids during reset keeps in_ready low without a wb-side path.
  vx_rr_lock_arbiter #(.N(NUM_INPUTS)) arb (
    .clk       (clk),
    .reset     (reset),
    .valid     (in_valid & {NUM_INPUTS{~reset}}),
    .lock      (state == WB_ARB_LOCKED),
    .lock_idx  (lock_src),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign in_ready  = grant;
  assign fire      = |grant;
  assign sel_sop   = in_sop[grant_idx];
  assign sel_eop   = in_eop[grant_idx];
  assign proto_err = fire && ((state == WB_ARB_IDLE) ? !sel_sop : sel_sop);

  // Malformed sequences are forwarded; the lock simply follows eop.
  always_comb begin
    state_n    = state;
    lock_src_n = lock_src;
    if (fire) begin
      if (state == WB_ARB_IDLE && !sel_eop) begin
        state_n    = WB_ARB_LOCKED;
        lock_src_n = grant_idx;
      end else if (state == WB_ARB_LOCKED && sel_eop) begin
        state_n = WB_ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WB_ARB_IDLE;
      lock_src <= '0;
    end else begin
      state    <= state_n;
      lock_src <= lock_src_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_uuid  <= '0;
      wb_wis   <= '0;
      wb_tmask <= '0;
      wb_PC    <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_sop   <= 1'b0;
      wb_eop   <= 1'b0;
    end else begin
      wb_valid <= fire;
      if (fire) begin
        wb_uuid  <= in_uuid[grant_idx*UUID_W +: UUID_W];
        wb_wis   <= in_wis[grant_idx*WIS_W +: WIS_W];
        wb_tmask <= in_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
        wb_PC    <= in_PC[grant_idx*XLEN +: XLEN];
        wb_rd    <= in_rd[grant_idx*NR_BITS +: NR_BITS];
        wb_data  <= in_data[grant_idx*DW +: DW];
        wb_sop   <= sel_sop;
        wb_eop   <= sel_eop;
      end
    end
  end

  wb_sop_eop_order: assert property (@(posedge clk) disable iff (reset) !proto_err)
    else $warning("vx_writeback_arb: sop/eop protocol error on source %0d", grant_idx);

endmodule
